// File: rtl/addsub_pkg.sv
// Shared types and defaults for the adder/subtractor result stage.
package addsub_pkg;

  // Operation codes presented on in_op.
  typedef enum logic [1:0] {
    OP_ADD     = 2'd0,
    OP_SUB     = 2'd1,
    OP_ACC_ADD = 2'd2,
    OP_ACC_SUB = 2'd3
  } op_e;

  // Occupancy of the single output register slot.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/addsub8.sv
// Combinational adder/subtractor: s = a + (b ^ {m}) + m.
// m = 1 turns the add into a two's-complement subtract; cout is then the
// inverted borrow.
module addsub8
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;

  assign b_eff   = b ^ {WIDTH{m}};
  assign sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, m};
  assign s       = sum_ext[WIDTH-1:0];
  assign cout    = sum_ext[WIDTH];

  // Signed overflow: both addends share a sign and the sum's sign differs.
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_result_stage.sv
// Registered wrapper around addsub8: valid/ready intake, one-deep result
// register with flags, chaining accumulator and accepted-operation counter.
module addsub_result_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  state_e           state_reg;
  logic [WIDTH-1:0] res_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             zero_reg;
  logic             neg_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] count_reg;

  logic             accept;
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] sum;
  logic             sum_cout;
  logic             sum_ovf;

  // in_op[1] selects the accumulator as operand A; in_op[0] selects subtract.
  assign adder_a = in_op[1] ? acc_reg : in_a;

  addsub8 #(
    .WIDTH (WIDTH)
  ) u_addsub8 (
    .a    (adder_a),
    .b    (in_b),
    .m    (in_op[0]),
    .s    (sum),
    .cout (sum_cout),
    .ovf  (sum_ovf)
  );

  // A full slot can still accept when the consumer drains it this cycle.
  assign in_ready = (state_reg == ST_EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  // Slot occupancy, result/flag capture, accumulator and op counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      res_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
      neg_reg   <= 1'b0;
      acc_reg   <= '0;
      count_reg <= '0;
    end else if (accept) begin
      // Accept takes priority over acc_clr so chained ops see their own result.
      state_reg <= ST_FULL;
      res_reg   <= sum;
      cout_reg  <= sum_cout;
      ovf_reg   <= sum_ovf;
      zero_reg  <= (sum == '0);
      neg_reg   <= sum[WIDTH-1];
      acc_reg   <= sum;
      count_reg <= count_reg + CNT_W'(1);
    end else begin
      if ((state_reg == ST_FULL) && out_ready) begin
        state_reg <= ST_EMPTY;
      end
      if (acc_clr) begin
        acc_reg <= '0;
      end
    end
  end

  assign out_valid = (state_reg == ST_FULL);
  assign out_res   = res_reg;
  assign out_cout  = cout_reg;
  assign out_ovf   = ovf_reg;
  assign out_zero  = zero_reg;
  assign out_neg   = neg_reg;
  assign acc       = acc_reg;
  assign op_count  = count_reg;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Directed testbench for addsub_result_stage with hand-computed expectations.
module tb_addsub_result_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_res;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;
  logic        out_neg;
  logic [7:0]  acc;
  logic [15:0] op_count;

  int tests_run;
  int tests_failed;

  addsub_result_stage #(
    .WIDTH (8),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .acc       (acc),
    .op_count  (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one rising edge and let registered outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  // Check the full result tuple in one go.
  task automatic check_res(input string tag, input logic [7:0] res, input logic c,
                           input logic o, input logic z, input logic n);
    check({tag, ".res"},  {24'd0, out_res}, {24'd0, res});
    check({tag, ".cout"}, {31'd0, out_cout}, {31'd0, c});
    check({tag, ".ovf"},  {31'd0, out_ovf},  {31'd0, o});
    check({tag, ".zero"}, {31'd0, out_zero}, {31'd0, z});
    check({tag, ".neg"},  {31'd0, out_neg},  {31'd0, n});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    step();
    rst = 1'b0;

    // Load something, then reset with a request still presented.
    drive(1'b1, 2'd0, 8'h11, 8'h22);
    step();
    check("pre_rst.valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst.res", {24'd0, out_res}, 32'h33);
    rst = 1'b1;
    step();
    step();
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check_res("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.acc", {24'd0, acc}, 32'd0);
    check("rst.count", {16'd0, op_count}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    out_ready = 1'b0;
    settle();
    check("rst.in_ready_empty", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // ADD 0x7F + 0x01: signed overflow into negative.
    drive(1'b1, 2'd0, 8'h7F, 8'h01);
    step();
    check("add7f.valid", {31'd0, out_valid}, 32'd1);
    check_res("add7f", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    check("add7f.count", {16'd0, op_count}, 32'd1);
    check("add7f.acc", {24'd0, acc}, 32'h80);

    // ADD 0xFF + 0x01: unsigned wrap, carry out, no overflow.
    drive(1'b1, 2'd0, 8'hFF, 8'h01);
    step();
    check_res("addff", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    // SUB 0x05 - 0x05.
    drive(1'b1, 2'd1, 8'h05, 8'h05);
    step();
    check_res("sub55", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    // SUB 0x03 - 0x05: borrow, cout = 0.
    drive(1'b1, 2'd1, 8'h03, 8'h05);
    step();
    check_res("sub35", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sub35.count", {16'd0, op_count}, 32'd4);

    // Back-to-back chain through the accumulator; in_a ignored for ACC ops.
    drive(1'b1, 2'd0, 8'h10, 8'h20);
    settle();
    check("chain0.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("chain0.res", {24'd0, out_res}, 32'h30);
    drive(1'b1, 2'd2, 8'hAA, 8'h05);
    settle();
    check("chain1.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("chain1.res", {24'd0, out_res}, 32'h35);
    drive(1'b1, 2'd3, 8'hAA, 8'h35);
    settle();
    check("chain2.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check_res("chain2", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    check("chain2.count", {16'd0, op_count}, 32'd7);

    // Backpressure: request waits, result held.
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 8'h01, 8'h02);
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("bp%0d.in_ready", i), {31'd0, in_ready}, 32'd0);
      step();
      check($sformatf("bp%0d.valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d.res", i), {24'd0, out_res}, 32'h00);
      check($sformatf("bp%0d.count", i), {16'd0, op_count}, 32'd7);
    end
    out_ready = 1'b1;
    settle();
    check("bp_rel.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_rel.res", {24'd0, out_res}, 32'h03);
    check("bp_rel.valid", {31'd0, out_valid}, 32'd1);
    check("bp_rel.count", {16'd0, op_count}, 32'd8);
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    step();
    check("drain.valid", {31'd0, out_valid}, 32'd0);
    check("drain.res", {24'd0, out_res}, 32'h03);

    // acc_clr together with an ACC op: op uses old acc and wins the write.
    drive(1'b1, 2'd0, 8'h40, 8'h00);
    step();
    check("acc40", {24'd0, acc}, 32'h40);
    acc_clr = 1'b1;
    drive(1'b1, 2'd2, 8'h00, 8'h01);
    step();
    check("clr_op.res", {24'd0, out_res}, 32'h41);
    check("clr_op.acc", {24'd0, acc}, 32'h41);
    out_ready = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    step();
    check("clr_only.acc", {24'd0, acc}, 32'h00);
    check("clr_only.res", {24'd0, out_res}, 32'h41);
    check("clr_only.valid", {31'd0, out_valid}, 32'd1);
    check("clr_only.count", {16'd0, op_count}, 32'd10);
    acc_clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/addsub_result_stage.md
Name: addsub_result_stage

Overview:
- Sequential wrapper that sits around the 8-bit combinational adder/subtractor.
- Upstream side: accepts operation requests through a valid/ready handshake and drives the adder's operands and its mode bit.
- Downstream side: registers the 8-bit result together with its flags, and holds them until the consumer takes them.
- Keeps an 8-bit accumulator, so operations can chain on the previous result.

Parameters:
- WIDTH, 8, operand/result width; only 8 is verified.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  stage can accept a request this cycle.
- in_op  in  2  operation code; see op_e.
- in_a  in  WIDTH  operand A; ignored for ACC ops.
- in_b  in  WIDTH  operand B.
- acc_clr  in  1  zero the accumulator.
- out_valid  out  1  result register holds an untaken result.
- out_ready  in  1  consumer takes the result.
- out_res  out  WIDTH  registered result.
- out_cout  out  1  registered carry-out of the adder (inverted borrow for SUB).
- out_ovf  out  1  signed two's-complement overflow.
- out_zero  out  1  out_res == 0.
- out_neg  out  1  out_res[WIDTH-1].
- acc  out  WIDTH  current accumulator value.
- op_count  out  CNT_W  number of accepted requests.

Behaviour:
- Reset (rst=1 at an edge) sets all of the following to 0: out_valid, out_res, out_cout, out_ovf, out_zero, out_neg, acc, op_count. The FSM goes to EMPTY. Reset overrides every other input, including an in-flight handshake.

Opcodes (op_e):
- ADD = 0: A + B, M = 0.
- SUB = 1: A - B, M = 1, computed as A + ~B + 1.
- ACC_ADD = 2: acc + B.
- ACC_SUB = 3: acc - B.
- For ops 2 and 3, the adder's A input is acc (the value before the edge).

Handshakes:
- Accept when in_valid && in_ready; produce when out_valid && out_ready.
- in_ready = (state == EMPTY) || out_ready. This is combinational from out_ready; a full stage passes through with no bubble.

FSM:
- EMPTY: on accept, go to FULL.
- FULL, out_ready=1: if accept, stay FULL (new result loaded); otherwise go to EMPTY.
- FULL, out_ready=0: stay FULL; outputs held stable and in_ready = 0.
- out_valid = (state == FULL).

Latency:
- The result is visible on out_* on the cycle after acceptance.
- Throughput is 1 operation per cycle while out_ready = 1.

On accept, the following are registered:
- out_res = adder sum.
- out_cout = adder carry-out.
- out_ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff = B ^ {WIDTH{M}}.
- out_zero and out_neg are computed from the sum.
- acc <= sum, for every op; ADD/SUB also load acc.
- op_count increments and wraps modulo 2^CNT_W.

Arithmetic:
- Modulo 2^WIDTH; no saturation.
- Example: 0xFF + 0x01 gives 0x00 with cout = 1 and ovf = 0.
- Example: 0x7F + 0x01 gives 0x80 with ovf = 1.

acc_clr:
- With no accept, acc <= 0 and nothing else changes.
- Same cycle as an accept of an ACC op: the op uses the pre-edge acc, and the op result is written to acc (accept wins over clear).
- Same cycle as an accept of ADD/SUB: the result is written to acc.
- acc_clr never affects out_* or out_valid.

Backpressure:
- While out_valid && !out_ready, the out_* signals must not change.
- in_valid may stay high; the request is not consumed.

Decomposition:
- Package addsub_pkg holds:
  - typedef enum logic [1:0] op_e {OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB};
  - typedef enum logic state_e {ST_EMPTY, ST_FULL};
  - localparam WIDTH_DEF = 8.
- Single sub-module addsub8: combinational, with inputs a, b, m and outputs s, cout, ovf.
  - Internally it computes b ^ {8{m}} with carry-in = m.
  - It is instantiated once, with m = in_op[0] and a muxed between in_a and acc by in_op[1].
- The flags and FSM live in the top.

Test Plan:
- Reset with in_valid=1 mid-operation, holding rst=1 for 2 cycles -> all outputs 0, out_valid=0; first accept afterwards has op_count=1.
- ADD 0x7F+0x01 -> next cycle out_res=0x80, ovf=1, neg=1, cout=0, zero=0.
- SUB 0x05-0x05 -> out_res=0x00, zero=1, cout=1.
- SUB 0x03-0x05 -> out_res=0xFE, neg=1, cout=0.
- Chain: ADD 0x10+0x20, then ACC_ADD B=0x05, then ACC_SUB B=0x35, all back-to-back with out_ready=1 -> results 0x30, 0x35, 0x00; in_ready stays 1 throughout.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_res held. Then out_ready=1 -> the held result is consumed and the pending request is accepted in the same cycle.
- acc_clr asserted together with ACC_ADD B=0x01 while acc=0x40 -> out_res=0x41, acc=0x41. Then acc_clr alone -> acc=0x00 and out_res stays 0x41.
